bcd_down_timer: RTL

Synchronous, parameterizable multi-digit BCD down-counter (countdown timer) that complements the decade up-counter in the same counter library. It loads a BCD preset, counts down one step per enabled clock with digit-wise borrow, and signals expiry with a one-cycle `done` pulse. Optional auto-reload turns it into a periodic divide-by-preset tick source. All state is in one clock domain, with no ripple clocks.

---
 rtl/bcd_down_timer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: loads a sanitized BCD preset, counts down
// with digit-wise borrow, pulses done on expiry and can auto-reload the preset.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] preset,
  input  logic                start,
  input  logic                pause,
  input  logic                reload_en,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                bcd_err,
  output logic [1:0]          dbg_state
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   count_q;
  logic           done_q;
  logic           bcd_err_q;

  logic [W-1:0]   preset_san;
  logic           preset_bad;
  logic [W-1:0]   count_dec;
  logic           borrow;
  logic           count_is_one;
  logic           count_is_zero;
  logic           preset_is_zero;

  // Out-of-range digits clamp to 9 so count can never hold a non-BCD digit.
  always_comb begin
    preset_san = preset;
    preset_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) begin
        preset_san[4*i +: 4] = 4'd9;
        preset_bad           = 1'b1;
      end
    end
  end

  // Ripple the borrow upward: a zero digit wraps to 9 and keeps borrowing.
  always_comb begin
    count_dec = count_q;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_is_one   = (count_q == W'(1));
  assign count_is_zero  = (count_q == '0);
  assign preset_is_zero = (preset_san == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        count_q   <= preset_san;
        bcd_err_q <= preset_bad;
        state_q   <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !count_is_zero) state_q <= RUN;
          end
          RUN: begin
            if (pause) begin
              state_q <= PAUSE;
            end else if (count_is_one) begin
              done_q <= 1'b1;
              if (reload_en && !preset_is_zero) begin
                count_q <= preset_san;
              end else begin
                count_q <= '0;
                state_q <= IDLE;
              end
            end else begin
              count_q <= count_dec;
            end
          end
          PAUSE: begin
            if (!pause) state_q <= RUN;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign count     = count_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign bcd_err   = bcd_err_q;
  assign dbg_state = state_q;

endmodule
